gcn_coo_aggregator: RTL and testbench
=====================================

# gcn_coo_aggregator

Parametrised adjacency-aggregation and classification stage of the GCN datapath. It accepts the per-node feature×weight product rows from the combination stage and walks a COO edge list one edge per cycle. Each destination node accumulates the product rows of its neighbours, with optional self-loops and symmetric (undirected) edges. It then emits a per-node argmax class address. It generalises the fixed 6-node / 6-edge / 3-class aggregation to arbitrary node, edge and class counts, and adds saturation and out-of-range edge detection.

## Interface
- NUM_OF_NODES, 6, nodes (product rows)
- NUM_OF_EDGES, 6, COO columns walked per run
- OUT_COLS, 3, classes per row (weight columns)
- DOT_PROD_WIDTH, 16, unsigned product element width
- ACC_WIDTH, DOT_PROD_WIDTH+$clog2(NUM_OF_NODES+1), accumulator width; must be ≥ DOT_PROD_WIDTH
- SELF_LOOP, 1, 1 = accumulator initialised with the node's own product row; 0 = initialised to zero
- SYMMETRIC, 1, 1 = each edge also contributes in the reverse direction
- NODE_BW, $clog2(NUM_OF_NODES), node index width
- EDGE_BW, $clog2(NUM_OF_EDGES), edge address width
- MAX_ADDRESS_WIDTH, $clog2(OUT_COLS), class address width

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  level request; a run begins on IDLE with start=1
- load_valid  in  1  product row beat valid
- load_ready  out  1  high only in LOAD
- load_row  in  OUT_COLS×DOT_PROD_WIDTH  product row; beats arrive in node order 0..N-1
- coo_address  out  EDGE_BW  edge index; the COO memory answers combinationally in the same cycle
- coo_in  in  2×NODE_BW  {src (upper), dst (lower)}
- row_sel  in  NODE_BW  readback select
- adj_row_out  out  OUT_COLS×ACC_WIDTH  accumulator row[row_sel], combinational read
- max_addr_out  out  NUM_OF_NODES×MAX_ADDRESS_WIDTH  argmax per node
- done_comb  out  1  results valid
- coo_err  out  1  sticky, set by an out-of-range edge

## Operation
- States: IDLE → LOAD → INIT → EDGE → ARGMAX → DONE → IDLE.
- IDLE: every output is 0. start=1 moves to LOAD and clears coo_err.
- LOAD: one row is captured per cycle with load_valid & load_ready, into prod[row_cnt]. The state exits after beat N-1. start is ignored from LOAD onward.
- INIT, 1 cycle: acc[i] = SELF_LOOP ? zero-extend(prod[i]) : 0, for all i.
- EDGE: coo_address = e, with e running 0..E-1.
  - If src ≥ N or dst ≥ N, the edge is skipped and coo_err is set.
  - Otherwise acc[dst] += prod[src].
  - If SYMMETRIC and src≠dst, acc[src] += prod[dst] in the same cycle.
  - Duplicate edges accumulate again.
  - A src==dst edge adds once, regardless of SELF_LOOP.
- Arithmetic: unsigned, element-wise, saturating at 2^ACC_WIDTH−1. No wrap-around is permitted.
- ARGMAX: one node per cycle, n running 0..N-1. max_addr[n] is the index of the largest acc[n][k]; on a tie the lowest index wins.
- DONE: done_comb=1 and results are held. When start=0 the block returns to IDLE and clears outputs. If start is still 1, it waits in DONE.
- coo_address is 0 outside EDGE. adj_row_out is 0 unless in DONE.
- reset in any state forces IDLE on the next edge, with all outputs, row_cnt, e and n at 0. Internal arrays need not clear.

## Timing
- LOAD takes ≥ N cycles (exactly N with load_valid held high).
- After the last load beat, the run takes 1 (INIT) + E (EDGE) + N (ARGMAX) cycles. done_comb rises on the following edge.
- Total latency from start=1 to done_comb with continuous valid: N + 1 + E + N + 1 cycles. Default parameters give 20.
- coo_in is sampled in the same cycle coo_address is driven. There is no read-latency register.
- max_addr_out[n] updates on the edge ending ARGMAX cycle n and stays stable until IDLE.

## Structure
- Package gcn_pkg holds:
  - the state enum typedef;
  - the saturating-add function, sat_add(a, b, width);
  - shared width localparams (NODE_BW, EDGE_BW, MAX_ADDRESS_WIDTH derivations).
- One sub-module, gcn_row_argmax. It is combinational: an OUT_COLS×ACC_WIDTH row in, MAX_ADDRESS_WIDTH index out, lowest index on ties. The top level instantiates it once and muxes acc[n] into it.
- Accumulator and product arrays are flops. No memory macro is used.

## Test plan
- Default params, SELF_LOOP=0, SYMMETRIC=0. prod[0]={5,9,2} with all other rows 0; all 6 edges are (0→1). Required: acc[1]={30,54,12}, max_addr[1]=1, other nodes 0, done_comb exactly 20 cycles after start.
- SELF_LOOP=1, SYMMETRIC=1, one edge (2↔3), other edges self (4→4). prod[2]={1,0,0}, prod[3]={0,4,0}, prod[4]={0,0,3}. Required:
  - acc[2]={1,4,0} and acc[3]={1,4,0}, so max_addr=1 for both;
  - acc[4]={0,0,3·6}; the self edge adds 5× on top of init, so max_addr[4]=2.
- Tie check: acc row {7,7,3} gives max_addr=0. A row of all zeros gives 0.
- Saturation with ACC_WIDTH=16: prod[0]={16'hC000,0,0} and two edges 0→1. Required: acc[1][0]=16'hFFFF, not wrapped.
- Out-of-range edge with N=6: edge 3 = (7→1). The edge must be skipped (acc[1] unchanged by it), coo_err=1 in DONE, and cleared by the next start.
- reset asserted during EDGE cycle 2. Required: IDLE with all outputs 0 on the next cycle. A subsequent full run then matches the golden result from the first scenario.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and helpers for the GCN COO aggregation stage.
package gcn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_EDGE,
    ST_ARGMAX,
    ST_DONE
  } state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_OF_NODES      = 6;
  localparam int DEF_NUM_OF_EDGES      = 6;
  localparam int DEF_OUT_COLS          = 3;
  localparam int DEF_NODE_BW           = idx_bw(DEF_NUM_OF_NODES);
  localparam int DEF_EDGE_BW           = idx_bw(DEF_NUM_OF_EDGES);
  localparam int DEF_MAX_ADDRESS_WIDTH = idx_bw(DEF_OUT_COLS);

  // Unsigned add clamped to 2^width-1 (width up to 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/gcn_coo_aggregator_if.sv
// Load handshake and COO edge-memory bus of the aggregation stage.
interface gcn_coo_aggregator_if #(
  parameter int OUT_COLS       = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NODE_BW        = 3,
  parameter int EDGE_BW        = 3
);
  logic                               load_valid;
  logic                               load_ready;
  logic [OUT_COLS*DOT_PROD_WIDTH-1:0] load_row;
  logic [EDGE_BW-1:0]                 coo_address;
  logic [2*NODE_BW-1:0]               coo_in;

  // Producer of product rows and owner of the COO memory.
  modport master (
    output load_valid, load_row, coo_in,
    input  load_ready, coo_address
  );

  // The aggregator itself.
  modport slave (
    input  load_valid, load_row, coo_in,
    output load_ready, coo_address
  );
endinterface

// File: rtl/gcn_row_argmax.sv
// Combinational argmax over one accumulator row; lowest index wins ties.
module gcn_row_argmax #(
  parameter int OUT_COLS          = 3,
  parameter int ACC_WIDTH         = 19,
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic [OUT_COLS*ACC_WIDTH-1:0] row_i,
  output logic [MAX_ADDRESS_WIDTH-1:0]  idx_o
);

  logic [ACC_WIDTH-1:0] best;

  // Strict greater-than keeps the earliest column on equal values.
  always_comb begin
    best  = row_i[ACC_WIDTH-1:0];
    idx_o = '0;
    for (int k = 1; k < OUT_COLS; k++) begin
      if (row_i[k*ACC_WIDTH +: ACC_WIDTH] > best) begin
        best  = row_i[k*ACC_WIDTH +: ACC_WIDTH];
        idx_o = MAX_ADDRESS_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/gcn_coo_aggregator.sv
// COO adjacency aggregation followed by per-node argmax classification.
module gcn_coo_aggregator
  import gcn_pkg::*;
#(
  parameter int NUM_OF_NODES      = DEF_NUM_OF_NODES,
  parameter int NUM_OF_EDGES      = DEF_NUM_OF_EDGES,
  parameter int OUT_COLS          = DEF_OUT_COLS,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int ACC_WIDTH         = DOT_PROD_WIDTH + $clog2(NUM_OF_NODES + 1),
  parameter int SELF_LOOP         = 1,
  parameter int SYMMETRIC         = 1,
  parameter int NODE_BW           = idx_bw(NUM_OF_NODES),
  parameter int EDGE_BW           = idx_bw(NUM_OF_EDGES),
  parameter int MAX_ADDRESS_WIDTH = idx_bw(OUT_COLS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  gcn_coo_aggregator_if.slave                   bus,
  input  logic [NODE_BW-1:0]                    row_sel,
  output logic [OUT_COLS*ACC_WIDTH-1:0]         adj_row_out,
  output logic [NUM_OF_NODES*MAX_ADDRESS_WIDTH-1:0] max_addr_out,
  output logic                                  done_comb,
  output logic                                  coo_err
);

  state_e                     state_q, state_d;
  logic [NODE_BW-1:0]         row_cnt_q, row_cnt_d;
  logic [EDGE_BW-1:0]         e_q, e_d;
  logic [NODE_BW-1:0]         n_q, n_d;
  logic                       coo_err_q, coo_err_d;
  logic [MAX_ADDRESS_WIDTH-1:0] max_addr_q [NUM_OF_NODES];

  logic [DOT_PROD_WIDTH-1:0]  prod_q [NUM_OF_NODES][OUT_COLS];
  logic [ACC_WIDTH-1:0]       acc_q  [NUM_OF_NODES][OUT_COLS];

  logic [NODE_BW-1:0]         src, dst, src_idx, dst_idx;
  logic                       edge_ok;
  logic [ACC_WIDTH-1:0]       sum_dst [OUT_COLS];
  logic [ACC_WIDTH-1:0]       sum_src [OUT_COLS];

  logic [OUT_COLS*ACC_WIDTH-1:0] argmax_row;
  logic [MAX_ADDRESS_WIDTH-1:0]  argmax_idx;

  // Next-state and counter sequencing for the run.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    e_d       = e_q;
    n_d       = n_q;
    coo_err_d = coo_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          coo_err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          if (row_cnt_q == NODE_BW'(NUM_OF_NODES - 1)) begin
            row_cnt_d = '0;
            state_d   = ST_INIT;
          end else begin
            row_cnt_d = row_cnt_q + NODE_BW'(1);
          end
        end
      end
      ST_INIT: state_d = ST_EDGE;
      ST_EDGE: begin
        if (!edge_ok) coo_err_d = 1'b1;
        if (e_q == EDGE_BW'(NUM_OF_EDGES - 1)) begin
          e_d     = '0;
          state_d = ST_ARGMAX;
        end else begin
          e_d = e_q + EDGE_BW'(1);
        end
      end
      ST_ARGMAX: begin
        if (n_q == NODE_BW'(NUM_OF_NODES - 1)) begin
          n_d     = '0;
          state_d = ST_DONE;
        end else begin
          n_d = n_q + NODE_BW'(1);
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d   = ST_IDLE;
          coo_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; results are cleared on reset and on leaving DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      e_q       <= '0;
      n_q       <= '0;
      coo_err_q <= 1'b0;
      for (int i = 0; i < NUM_OF_NODES; i++) max_addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      e_q       <= e_d;
      n_q       <= n_d;
      coo_err_q <= coo_err_d;
      if (state_q == ST_ARGMAX) begin
        max_addr_q[n_q] <= argmax_idx;
      end else if (state_q == ST_DONE && !start) begin
        for (int i = 0; i < NUM_OF_NODES; i++) max_addr_q[i] <= '0;
      end
    end
  end

  // Decode the current edge and form both saturating neighbour sums.
  always_comb begin
    src     = bus.coo_in[2*NODE_BW-1:NODE_BW];
    dst     = bus.coo_in[NODE_BW-1:0];
    edge_ok = (int'(src) < NUM_OF_NODES) && (int'(dst) < NUM_OF_NODES);
    src_idx = edge_ok ? src : '0;
    dst_idx = edge_ok ? dst : '0;
    for (int k = 0; k < OUT_COLS; k++) begin
      sum_dst[k] = ACC_WIDTH'(sat_add(64'(acc_q[dst_idx][k]),
                                      64'(prod_q[src_idx][k]), ACC_WIDTH));
      sum_src[k] = ACC_WIDTH'(sat_add(64'(acc_q[src_idx][k]),
                                      64'(prod_q[dst_idx][k]), ACC_WIDTH));
    end
  end

  // Product capture, accumulator init and per-edge accumulation.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && bus.load_valid) begin
      for (int k = 0; k < OUT_COLS; k++)
        prod_q[row_cnt_q][k] <= bus.load_row[k*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
    end
    if (state_q == ST_INIT) begin
      for (int i = 0; i < NUM_OF_NODES; i++)
        for (int k = 0; k < OUT_COLS; k++)
          acc_q[i][k] <= (SELF_LOOP != 0) ? ACC_WIDTH'(prod_q[i][k]) : '0;
    end
    if (state_q == ST_EDGE && edge_ok) begin
      for (int k = 0; k < OUT_COLS; k++) begin
        acc_q[dst_idx][k] <= sum_dst[k];
        if (SYMMETRIC != 0 && src_idx != dst_idx) acc_q[src_idx][k] <= sum_src[k];
      end
    end
  end

  // Present the node currently being classified to the argmax unit.
  always_comb begin
    argmax_row = '0;
    for (int k = 0; k < OUT_COLS; k++)
      argmax_row[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[n_q][k];
  end

  gcn_row_argmax #(
    .OUT_COLS          (OUT_COLS),
    .ACC_WIDTH         (ACC_WIDTH),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_argmax (
    .row_i (argmax_row),
    .idx_o (argmax_idx)
  );

  // Output drive; everything reads zero outside its owning state.
  always_comb begin
    bus.load_ready  = (state_q == ST_LOAD);
    bus.coo_address = (state_q == ST_EDGE) ? e_q : '0;
    done_comb       = (state_q == ST_DONE);
    coo_err         = coo_err_q;
    adj_row_out     = '0;
    if (state_q == ST_DONE && int'(row_sel) < NUM_OF_NODES) begin
      for (int k = 0; k < OUT_COLS; k++)
        adj_row_out[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_sel][k];
    end
    for (int i = 0; i < NUM_OF_NODES; i++)
      max_addr_out[i*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] = max_addr_q[i];
  end

endmodule

// File: tb/tb_gcn_coo_aggregator.sv
// Bench for gcn_coo_aggregator: two configurations run in lockstep, scoreboard-checked.
module tb_gcn_coo_aggregator;

  localparam int N   = 6;
  localparam int E   = 6;
  localparam int C   = 3;
  localparam int DW  = 16;
  localparam int NBW = 3;
  localparam int EBW = 3;
  localparam int MAW = 2;
  localparam int AW0 = 16;
  localparam int AW1 = DW + $clog2(N + 1);

  typedef struct packed {
    logic             dut;
    logic [2:0]       node;
    logic [2:0][31:0] acc;
    logic [1:0]       maxa;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NBW-1:0] row_sel0, row_sel1;
  logic [C*AW0-1:0] adj0;
  logic [C*AW1-1:0] adj1;
  logic [N*MAW-1:0] max0, max1;
  logic           done0, done1, err0, err1;

  int   prodT [2][N][C];
  int   srcT  [2][E];
  int   dstT  [2][E];
  bit   exp_err [2];
  exp_t sbq [$];
  int   n_checks = 0;
  int   n_errors = 0;

  gcn_coo_aggregator_if #(.OUT_COLS(C), .DOT_PROD_WIDTH(DW), .NODE_BW(NBW), .EDGE_BW(EBW)) bus0 ();
  gcn_coo_aggregator_if #(.OUT_COLS(C), .DOT_PROD_WIDTH(DW), .NODE_BW(NBW), .EDGE_BW(EBW)) bus1 ();

  gcn_coo_aggregator #(
    .NUM_OF_NODES(N), .NUM_OF_EDGES(E), .OUT_COLS(C), .DOT_PROD_WIDTH(DW),
    .ACC_WIDTH(AW0), .SELF_LOOP(0), .SYMMETRIC(0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(bus0), .row_sel(row_sel0),
    .adj_row_out(adj0), .max_addr_out(max0), .done_comb(done0), .coo_err(err0)
  );

  gcn_coo_aggregator #(
    .NUM_OF_NODES(N), .NUM_OF_EDGES(E), .OUT_COLS(C), .DOT_PROD_WIDTH(DW),
    .SELF_LOOP(1), .SYMMETRIC(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(bus1), .row_sel(row_sel1),
    .adj_row_out(adj1), .max_addr_out(max1), .done_comb(done1), .coo_err(err1)
  );

  always #5 clk = ~clk;

  // COO memories answer in the same cycle.
  always_comb begin
    bus0.coo_in = {NBW'(srcT[0][bus0.coo_address]), NBW'(dstT[0][bus0.coo_address])};
    bus1.coo_in = {NBW'(srcT[1][bus1.coo_address]), NBW'(dstT[1][bus1.coo_address])};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] get_acc(input int d, input int k);
    if (d == 0) return 64'(adj0[k*AW0 +: AW0]);
    return 64'(adj1[k*AW1 +: AW1]);
  endfunction

  function automatic logic [63:0] get_max(input int d, input int n);
    if (d == 0) return 64'(max0[n*MAW +: MAW]);
    return 64'(max1[n*MAW +: MAW]);
  endfunction

  task automatic drive_rows(input int beat);
    if (beat < N) begin
      for (int k = 0; k < C; k++) begin
        bus0.load_row[k*DW +: DW] = DW'(prodT[0][beat][k]);
        bus1.load_row[k*DW +: DW] = DW'(prodT[1][beat][k]);
      end
    end else begin
      bus0.load_row = '0;
      bus1.load_row = '0;
    end
  endtask

  // Reference model: SELF_LOOP/SYMMETRIC/width taken from the instance config.
  task automatic push_expected(input int d);
    longint acc [N][C];
    longint lim;
    bit     sl, sym;
    int     s, t, best;
    exp_t   x;
    sl  = (d == 1);
    sym = (d == 1);
    lim = (longint'(1) << ((d == 0) ? AW0 : AW1)) - 1;
    exp_err[d] = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < C; k++) acc[i][k] = sl ? longint'(prodT[d][i][k]) : 0;
    for (int e = 0; e < E; e++) begin
      s = srcT[d][e];
      t = dstT[d][e];
      if (s >= N || t >= N) begin
        exp_err[d] = 1'b1;
      end else begin
        for (int k = 0; k < C; k++) begin
          acc[t][k] += prodT[d][s][k];
          if (acc[t][k] > lim) acc[t][k] = lim;
        end
        if (sym && s != t) begin
          for (int k = 0; k < C; k++) begin
            acc[s][k] += prodT[d][t][k];
            if (acc[s][k] > lim) acc[s][k] = lim;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      x.dut  = 1'(d);
      x.node = 3'(i);
      best   = 0;
      for (int k = 0; k < C; k++) begin
        x.acc[k] = 32'(acc[i][k]);
        if (acc[i][k] > acc[i][best]) best = k;
      end
      x.maxa = 2'(best);
      sbq.push_back(x);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_done"},  64'({done1, done0}), 64'd0);
    check_eq({tag, "_err"},   64'({err1, err0}), 64'd0);
    check_eq({tag, "_adj0"},  64'(adj0), 64'd0);
    check_eq({tag, "_adj1"},  64'(adj1), 64'd0);
    check_eq({tag, "_max"},   64'({max1, max0}), 64'd0);
    check_eq({tag, "_ready"}, 64'({bus1.load_ready, bus0.load_ready}), 64'd0);
    check_eq({tag, "_addr"},  64'({bus1.coo_address, bus0.coo_address}), 64'd0);
  endtask

  task automatic clear_tables();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < C; k++) prodT[d][i][k] = 0;
      for (int e = 0; e < E; e++) begin
        srcT[d][e] = 0;
        dstT[d][e] = 0;
      end
    end
  endtask

  // dut0: six copies of edge 0->1; dut1: 2<->3 plus self edges on node 4.
  task automatic setup_golden();
    clear_tables();
    prodT[0][0] = '{5, 9, 2};
    for (int e = 0; e < E; e++) begin
      srcT[0][e] = 0; dstT[0][e] = 1;
      srcT[1][e] = 4; dstT[1][e] = 4;
    end
    srcT[1][0] = 2; dstT[1][0] = 3;
    prodT[1][2] = '{1, 0, 0};
    prodT[1][3] = '{0, 4, 0};
    prodT[1][4] = '{0, 0, 3};
  endtask

  // dut0: saturation, tie row and an out-of-range edge; dut1: random graph.
  task automatic setup_second();
    clear_tables();
    prodT[0][0] = '{32'hC000, 0, 0};
    prodT[0][5] = '{7, 7, 3};
    srcT[0][0] = 0; dstT[0][0] = 1;
    srcT[0][1] = 0; dstT[0][1] = 1;
    srcT[0][2] = 5; dstT[0][2] = 0;
    srcT[0][3] = 7; dstT[0][3] = 1;
    srcT[0][4] = 2; dstT[0][4] = 2;
    srcT[0][5] = 2; dstT[0][5] = 2;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < C; k++) prodT[1][i][k] = int'($urandom_range(0, 1000));
    for (int e = 0; e < E; e++) begin
      srcT[1][e] = int'($urandom_range(0, N - 1));
      dstT[1][e] = int'($urandom_range(0, N - 1));
    end
  endtask

  task automatic run_scn(input bit abort);
    int   cyc;
    int   beat;
    bit   hs;
    bit   finished;
    exp_t x;
    if (!abort) begin
      push_expected(0);
      push_expected(1);
    end
    @(negedge clk);
    start = 1'b1;
    bus0.load_valid = 1'b1;
    bus1.load_valid = 1'b1;
    beat = 0;
    drive_rows(0);
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 100) begin
      hs = bus0.load_ready;
      @(posedge clk);
      cyc++;
      if (hs) beat++;
      #1;
      drive_rows(beat);
      if (cyc == 1) begin
        check_eq("load_entry_err", 64'({err1, err0}), 64'd0);
        check_eq("load_entry_ready", 64'({bus1.load_ready, bus0.load_ready}), 64'd3);
      end
      if (abort && cyc == 10) begin
        check_eq("edge2_addr", 64'(bus0.coo_address), 64'd2);
        reset = 1'b1;
        start = 1'b0;
        bus0.load_valid = 1'b0;
        bus1.load_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        finished = 1'b1;
      end else if (done0 && done1) begin
        finished = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!abort) begin
      check_eq("latency", 64'(cyc), 64'(N + 1 + E + N + 1));
      bus0.load_valid = 1'b0;
      bus1.load_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("done_hold", 64'({done1, done0}), 64'd3);
      check_eq("coo_err0", 64'(err0), 64'(exp_err[0]));
      check_eq("coo_err1", 64'(err1), 64'(exp_err[1]));
      while (sbq.size() > 0) begin
        x = sbq.pop_front();
        @(negedge clk);
        if (x.dut == 1'b0) row_sel0 = x.node;
        else               row_sel1 = x.node;
        #1;
        for (int k = 0; k < C; k++)
          check_eq($sformatf("acc_d%0d_n%0d_c%0d", x.dut, x.node, k),
                   get_acc(int'(x.dut), k), 64'(x.acc[k]));
        check_eq($sformatf("max_d%0d_n%0d", x.dut, x.node),
                 get_max(int'(x.dut), int'(x.node)), 64'(x.maxa));
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_outputs_zero("return_idle");
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    row_sel0 = '0;
    row_sel1 = '0;
    bus0.load_valid = 1'b0;
    bus1.load_valid = 1'b0;
    bus0.load_row = '0;
    bus1.load_row = '0;
    clear_tables();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("reset");

    setup_golden();
    run_scn(1'b0);
    setup_second();
    run_scn(1'b0);
    setup_golden();
    run_scn(1'b1);
    run_scn(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
